sync_fifo_wr_arb: RTL and testbench

Round-robin write arbiter that shares the write port of one sync FIFO among NUM_REQ requesters. Each requester offers packets as valid/ready beats. A packet may span multiple beats, and once its first beat is accepted the requester owns the FIFO write port until its last beat. The block sits directly in front of the FIFO. It drives the FIFO's din/wr_en and observes its full flag; the FIFO read side is untouched.

---
 rtl/sync_fifo_wr_arb.sv | 111 +++++++++++
 tb/tb_sync_fifo_wr_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin write arbiter sharing one sync FIFO write port among NUM_REQ
// requesters. A packet locks the port from its first accepted beat to its
// last. The granted requester's beat reaches fifo_din/fifo_wr_en combinationally.
//
//   state | meaning
//   IDLE  | no packet in flight; winner chosen round-robin from rr_ptr
//   LOCK  | owner is mid-packet; all other requesters are ignored
module sync_fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          grant_valid,
    output logic                          busy,
    output logic                          burst_err
);

    localparam int IW = $clog2(NUM_REQ);
    // Beat counter must hold MAX_BURST+1, where it saturates.
    localparam int CW = $clog2(MAX_BURST + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LIM  = CW'(MAX_BURST);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [CW-1:0]   beat_cnt;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   idx;
    logic            found;
    logic [IW-1:0]   gid;
    logic [IW-1:0]   next_ptr;
    logic            is_last;
    logic            over_limit;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign gid      = (state == LOCK) ? owner : winner;
    assign next_ptr = (gid == LAST_IDX) ? '0 : gid + 1'b1;
    assign is_last  = req_last[gid];
    // The beat about to be accepted in LOCK is number beat_cnt+1.
    assign over_limit = (state == LOCK) && (beat_cnt >= CNT_LIM);
    assign busy       = (state == LOCK);

    // Grant and write-port steering; everything is held quiet during reset.
    always_comb begin
        grant_valid = !rst && ((state == LOCK) || (|req_valid));
        grant_id    = rst ? '0 : gid;
        req_ready   = '0;
        if (grant_valid && !fifo_full) begin
            req_ready[gid] = 1'b1;
        end
        fifo_wr_en = req_valid[gid] & req_ready[gid];
        fifo_din   = req_data[gid*DATA_WIDTH +: DATA_WIDTH];
    end

    // Packet FSM, round-robin pointer, beat counter and burst error pulse.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            burst_err <= 1'b0;
        end else begin
            burst_err <= 1'b0;
            if (fifo_wr_en) begin
                burst_err <= over_limit;
                if (is_last) begin
                    state    <= IDLE;
                    rr_ptr   <= next_ptr;
                    beat_cnt <= '0;
                end else begin
                    state <= LOCK;
                    owner <= gid;
                    if (state == IDLE) begin
                        beat_cnt <= CW'(1);
                    end else if (beat_cnt != CNT_SAT) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Bench for sync_fifo_wr_arb: directed scenarios plus random traffic, all
// checked against a packet-level reference model of the arbiter.
module tb_sync_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int MB = 4;

    logic            clock = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   fifo_din;
    logic            fifo_wr_en;
    logic            fifo_full;
    logic [1:0]      grant_id;
    logic            grant_valid;
    logic            busy;
    logic            burst_err;

    always #5 clock = ~clock;

    sync_fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clock(clock), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full), .grant_id(grant_id), .grant_valid(grant_valid),
        .busy(busy), .burst_err(burst_err)
    );

    // Per-requester beat queues: {last, data}.
    logic [DW:0]   q [N][$];
    int            n_cmp = 0;
    int            n_err = 0;

    // Reference model: packet-level view of the arbiter.
    bit            m_lock;
    int            m_ptr, m_owner, m_len;
    bit            m_err;
    int            e_gid;
    bit            e_gv, e_wr;
    logic [N-1:0]  e_ready;

    logic [DW-1:0] wlog[$];
    int            wcyc[$];
    int            cyc = 0;
    int            busy_cycles, err_pulses;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_last[i]          = q[i][0][DW];
                req_data[i*DW +: DW] = q[i][0][DW-1:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_ptr = 0; m_owner = 0; m_len = 0; m_err = 0;
    endtask

    task automatic predict();
        if (m_lock) begin
            e_gv  = 1;
            e_gid = m_owner;
        end else begin
            e_gv  = |req_valid;
            e_gid = 0;
            for (int k = N - 1; k >= 0; k--)
                if (req_valid[(m_ptr + k) % N]) e_gid = (m_ptr + k) % N;
        end
        e_ready = '0;
        if (e_gv && !fifo_full) e_ready[e_gid] = 1'b1;
        e_wr = e_gv && !fifo_full && req_valid[e_gid];
    endtask

    // One clock: drive, check combinational outputs, clock, check registered ones.
    task automatic cycle();
        logic [N-1:0] hs;
        bit           lb;
        int           len;
        drive();
        #1;
        predict();
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("fifo_wr_en", 64'(fifo_wr_en), 64'(e_wr));
        chk("grant_valid", 64'(grant_valid), 64'(e_gv));
        if (e_gv) chk("grant_id", 64'(grant_id), 64'(e_gid));
        if (e_wr) chk("fifo_din", fifo_din, req_data[e_gid*DW +: DW]);
        if (fifo_wr_en) begin
            wlog.push_back(fifo_din);
            wcyc.push_back(cyc);
        end
        hs = req_valid & req_ready;
        lb = req_last[e_gid];
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (hs[i] && q[i].size() > 0) q[i].delete(0);
        if (e_wr) begin
            len   = m_lock ? m_len + 1 : 1;
            m_err = (len > MB);
            if (lb) begin
                m_lock = 0; m_ptr = (e_gid + 1) % N; m_len = 0;
            end else begin
                m_lock = 1; m_owner = e_gid; m_len = len;
            end
        end else begin
            m_err = 0;
        end
        chk("busy", 64'(busy), 64'(m_lock));
        chk("burst_err", 64'(burst_err), 64'(m_err));
        if (busy) busy_cycles++;
        if (burst_err) err_pulses++;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_wr_en"}, 64'(fifo_wr_en), 64'(0));
        chk({tag, "_gvalid"}, 64'(grant_valid), 64'(0));
        chk({tag, "_gid"}, 64'(grant_id), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_berr"}, 64'(burst_err), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive();
        #1;
        model_reset();
        @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) q[i].delete();
        wlog.delete();
        wcyc.delete();
    endtask

    function automatic int pending();
        int p = 0;
        for (int i = 0; i < N; i++) p += q[i].size();
        return p;
    endfunction

    task automatic drain(input int max_cycles);
        int c = 0;
        while (pending() > 0 && c < max_cycles) begin
            cycle();
            c++;
        end
        chk("drain_timeout", 64'(pending()), 64'(0));
    endtask

    task automatic chk_log(input string tag, input logic [DW-1:0] exp[$]);
        chk({tag, "_count"}, 64'(wlog.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < wlog.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), wlog[i], exp[i]);
    endtask

    task automatic push_pkt(input int r, input int len);
        for (int b = 0; b < len; b++)
            q[r].push_back({(b == len - 1) ? 1'b1 : 1'b0, 32'($urandom), 32'($urandom)});
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        model_reset();

        // Reset state, with a requester already valid.
        clear_all();
        q[1].push_back({1'b1, 64'h77});
        drive();
        #2;
        check_zero_outputs("reset");
        @(posedge clock);
        #1;
        rst = 1'b0;
        clear_all();

        // Single 1-beat packet from req 2; then rr_ptr=3 must favour req 3 over req 0.
        q[2].push_back({1'b1, 64'hA5});
        drive();
        #1;
        chk("single_wr_en", 64'(fifo_wr_en), 64'(1));
        chk("single_din", fifo_din, 64'hA5);
        chk("single_ready", 64'(req_ready), 64'(4'b0100));
        cycle();
        chk("single_busy", 64'(busy), 64'(0));
        q[0].push_back({1'b1, 64'hB0});
        q[3].push_back({1'b1, 64'hB3});
        drain(10);
        chk_log("single", '{64'hA5, 64'hB3, 64'hB0});

        // Round robin with all four requesters streaming 1-beat packets.
        do_reset();
        clear_all();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) q[i].push_back({1'b1, 64'(i)});
        repeat (8) cycle();
        chk_log("rr", '{64'd0, 64'd1, 64'd2, 64'd3, 64'd0, 64'd1, 64'd2, 64'd3});

        // Lock: req 1 three-beat packet while req 0 waits (rr_ptr first moved to 1).
        do_reset();
        clear_all();
        q[0].push_back({1'b1, 64'h0F});
        cycle();
        q[1].push_back({1'b0, 64'h10});
        q[1].push_back({1'b0, 64'h11});
        q[1].push_back({1'b1, 64'h12});
        q[0].push_back({1'b1, 64'h00});
        busy_cycles = 0;
        drain(20);
        chk_log("lock", '{64'h0F, 64'h10, 64'h11, 64'h12, 64'h00});
        chk("lock_busy_cycles", 64'(busy_cycles), 64'(2));

        // Backpressure during beat 2 of a req 3 packet.
        do_reset();
        clear_all();
        q[3].push_back({1'b0, 64'h30});
        q[3].push_back({1'b0, 64'h31});
        q[3].push_back({1'b1, 64'h32});
        cycle();
        fifo_full = 1'b1;
        repeat (3) begin
            drive();
            #1;
            chk("bp_wr_en", 64'(fifo_wr_en), 64'(0));
            chk("bp_gid", 64'(grant_id), 64'(3));
            #1;
            cycle();
        end
        fifo_full = 1'b0;
        drain(10);
        chk_log("bp", '{64'h30, 64'h31, 64'h32});

        // Burst error: six-beat packet with MAX_BURST=4.
        do_reset();
        clear_all();
        for (int b = 0; b < 6; b++) q[0].push_back({(b == 5) ? 1'b1 : 1'b0, 64'(8'h50 + b)});
        err_pulses = 0;
        drain(20);
        cycle();
        chk("berr_pulses", 64'(err_pulses), 64'(2));
        chk_log("berr", '{64'h50, 64'h51, 64'h52, 64'h53, 64'h54, 64'h55});
        if (wcyc.size() == 6) chk("berr_contiguous", 64'(wcyc[5] - wcyc[0]), 64'(5));

        // Reset in the middle of a req 2 packet; req 0 must win first afterwards.
        do_reset();
        clear_all();
        q[2].push_back({1'b0, 64'h20});
        q[2].push_back({1'b0, 64'h21});
        q[2].push_back({1'b1, 64'h22});
        cycle();
        chk("midrst_busy_before", 64'(busy), 64'(1));
        q[0].push_back({1'b1, 64'h0A});
        rst = 1'b1;
        drive();
        #1;
        model_reset();
        check_zero_outputs("midrst");
        @(posedge clock);
        #1;
        rst = 1'b0;
        wlog.delete();
        wcyc.delete();
        drain(20);
        chk_log("midrst", '{64'h0A, 64'h21, 64'h22});

        // Random traffic with random backpressure.
        do_reset();
        clear_all();
        for (int c = 0; c < 600; c++) begin
            fifo_full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++)
                if (q[i].size() == 0 && $urandom_range(0, 2) == 0)
                    push_pkt(i, $urandom_range(1, 6));
            cycle();
        end
        fifo_full = 1'b0;
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
